// File: rtl/indice_permutacao_pkg.sv
// Shared constants for the permutation generator / rank pair: widths, FSM encoding
// and Lehmer-code weights, so both directions agree on the same ordering table.
package indice_permutacao_pkg;

    localparam int IDX_W    = 5;
    localparam int ELEM_W   = 2;
    localparam int N_ELEM   = 4;
    localparam int PERM_W   = N_ELEM * ELEM_W;
    localparam int RANK_MAX = 23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RANK  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [IDX_W-1:0] LEHMER_W0 = 5'd6;
    localparam logic [IDX_W-1:0] LEHMER_W1 = 5'd2;
    localparam logic [IDX_W-1:0] LEHMER_W2 = 5'd1;

    function automatic logic [IDX_W-1:0] lehmer_weight(input logic [1:0] i);
        case (i)
            2'd0:    return LEHMER_W0;
            2'd1:    return LEHMER_W1;
            default: return LEHMER_W2;
        endcase
    endfunction

    // Element 0 lives in the most significant pair of bits.
    function automatic logic [ELEM_W-1:0] elem_at(input logic [PERM_W-1:0] p, input int k);
        return p[(N_ELEM-1-k)*ELEM_W +: ELEM_W];
    endfunction

endpackage

// File: rtl/indice_permutacao_conta_menores.sv
// Combinational Lehmer digit: how many elements after position i are smaller
// than element i. Position 3 has no successors and always yields 0.
module conta_menores
    import indice_permutacao_pkg::*;
(
    input  logic [PERM_W-1:0] p_reg,
    input  logic [1:0]        i,
    output logic [1:0]        d
);

    always_comb begin
        d = 2'd0;
        for (int j = 0; j < N_ELEM; j++) begin
            if (j > int'(i) && elem_at(p_reg, j) < elem_at(p_reg, int'(i))) begin
                d = d + 2'd1;
            end
        end
    end

endmodule

// File: rtl/indice_permutacao.sv
// Lexicographic rank (0..23) of a 4-element permutation of 2-bit indices.
// Optional macro RANK_ERR_CNT_EN adds a saturating count of rejected (duplicate) inputs.
module indice_permutacao
    import indice_permutacao_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [PERM_W-1:0] perm,
    output logic [IDX_W-1:0]  indice,
    output logic              done,
    output logic              erro,
    output logic              busy
`ifdef RANK_ERR_CNT_EN
    ,
    output logic [7:0]        erros_cnt
`endif
);

    state_t            state;
    state_t            state_next;
    logic [PERM_W-1:0] p_reg;
    logic [IDX_W-1:0]  acc;
    logic [IDX_W-1:0]  acc_next;
    logic [1:0]        i_cnt;
    logic [1:0]        d;
    logic              dup;

    conta_menores u_conta_menores (
        .p_reg (p_reg),
        .i     (i_cnt),
        .d     (d)
    );

    always_comb begin
        dup = 1'b0;
        for (int a = 0; a < N_ELEM; a++) begin
            for (int b = a + 1; b < N_ELEM; b++) begin
                if (elem_at(p_reg, a) == elem_at(p_reg, b)) begin
                    dup = 1'b1;
                end
            end
        end
    end

    // Max sum is 3*6 + 2*2 + 1 = 23, so 5 bits never wrap.
    assign acc_next = acc + ({3'b000, d} * lehmer_weight(i_cnt));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = CHECK;
            CHECK: state_next = dup ? DONE : RANK;
            RANK:  if (i_cnt == 2'd2) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // done/busy are decoded from the next state so they line up with the state register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            p_reg  <= '0;
            acc    <= '0;
            i_cnt  <= '0;
            indice <= '0;
            erro   <= 1'b0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= (state_next == DONE);
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        p_reg <= perm;
                        acc   <= '0;
                        i_cnt <= '0;
                    end
                end
                CHECK: begin
                    if (dup) begin
                        erro   <= 1'b1;
                        indice <= '0;
                    end
                end
                RANK: begin
                    acc   <= acc_next;
                    i_cnt <= i_cnt + 2'd1;
                    if (i_cnt == 2'd2) begin
                        indice <= acc_next;
                        erro   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef RANK_ERR_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            erros_cnt <= '0;
        end else if (state == CHECK && dup && erros_cnt != 8'hFF) begin
            erros_cnt <= erros_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_indice_permutacao.sv
// Self-checking bench for indice_permutacao against a lexicographic-table model.
// Error-counter scenarios are compiled only when RANK_ERR_CNT_EN is defined.
module tb_indice_permutacao;

    logic       clock;
    logic       reset;
    logic       start;
    logic [7:0] perm;
    logic [4:0] indice;
    logic       done;
    logic       erro;
    logic       busy;
`ifdef RANK_ERR_CNT_EN
    logic [7:0] erros_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] tbl[$];

    indice_permutacao dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .perm   (perm),
        .indice (indice),
        .done   (done),
        .erro   (erro),
        .busy   (busy)
`ifdef RANK_ERR_CNT_EN
        ,
        .erros_cnt (erros_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
        $fatal(1, "timeout");
    end

    // All distinct 4-tuples enumerated in lexicographic order; the position is the rank.
    task automatic build_table();
        tbl.delete();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 4; c++)
                    for (int e = 0; e < 4; e++)
                        if (a != b && a != c && a != e && b != c && b != e && c != e)
                            tbl.push_back({2'(a), 2'(b), 2'(c), 2'(e)});
    endtask

    task automatic ref_model(input logic [7:0] p, output logic [4:0] r, output logic dupl);
        int occ[4];
        for (int k = 0; k < 4; k++) occ[k] = 0;
        for (int k = 0; k < 4; k++) occ[p[2*k +: 2]]++;
        dupl = 1'b0;
        for (int k = 0; k < 4; k++) if (occ[k] > 1) dupl = 1'b1;
        r = 5'd0;
        if (!dupl)
            for (int k = 0; k < tbl.size(); k++)
                if (tbl[k] == p) r = 5'(k);
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b0; start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // Runs one job; lat = number of edges after the accepting edge until done is seen (-1 if never).
    task automatic do_job(input logic [7:0] p, output int lat, output logic [4:0] idx,
                          output logic e, output int busy_low);
        @(posedge clock); #1;
        perm = p; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        perm = 8'($urandom);
        lat = -1; idx = '0; e = 1'b0; busy_low = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy) busy_low++;
            if (done) begin
                lat = k; idx = indice; e = erro;
                break;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        do_reset();
        if (indice !== 5'd0) begin errors++; $display("FAIL reset_indice: actual %0d required 0", indice); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: actual %b required 0", done); end
        checks++;
        if (erro !== 1'b0) begin errors++; $display("FAIL reset_erro: actual %b required 0", erro); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: actual %b required 0", busy); end
        checks++;
    endtask

    task automatic test_known();
        logic [7:0] pats[3];
        int lat, bl;
        logic [4:0] idx, r;
        logic e, dp;
        pats[0] = 8'h1B; pats[1] = 8'hE4; pats[2] = 8'h4B;
        for (int n = 0; n < 3; n++) begin
            ref_model(pats[n], r, dp);
            do_job(pats[n], lat, idx, e, bl);
            if (lat !== 4) begin errors++; $display("FAIL known_latency %h: actual %0d required 4", pats[n], lat); end
            checks++;
            if (idx !== r) begin errors++; $display("FAIL known_indice %h: actual %0d required %0d", pats[n], idx, r); end
            checks++;
            if (e !== 1'b0) begin errors++; $display("FAIL known_erro %h: actual %b required 0", pats[n], e); end
            checks++;
            if (bl != 0) begin errors++; $display("FAIL known_busy %h: busy low %0d cycles required 0", pats[n], bl); end
            checks++;
            @(posedge clock); #1;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL known_after_done %h: done=%b busy=%b required 0 0", pats[n], done, busy);
            end
            checks++;
        end
    endtask

    task automatic test_round_trip();
        int lat, bl;
        logic [4:0] idx;
        logic e;
        for (int n = 0; n < 24; n++) begin
            do_job(tbl[n], lat, idx, e, bl);
            if (idx !== 5'(n) || e !== 1'b0 || lat !== 4) begin
                errors++;
                $display("FAIL round_trip %0d: actual indice=%0d erro=%b lat=%0d required indice=%0d erro=0 lat=4",
                         n, idx, e, lat, n);
            end
            checks++;
        end
    endtask

    task automatic test_invalid();
        int lat, bl;
        logic [4:0] idx;
        logic e;
        do_job(8'h06, lat, idx, e, bl);
        if (lat !== 1) begin errors++; $display("FAIL invalid_latency: actual %0d required 1", lat); end
        checks++;
        if (e !== 1'b1) begin errors++; $display("FAIL invalid_erro: actual %b required 1", e); end
        checks++;
        if (idx !== 5'd0) begin errors++; $display("FAIL invalid_indice: actual %0d required 0", idx); end
        checks++;
        do_job(8'hE4, lat, idx, e, bl);
        if (e !== 1'b0 || idx !== 5'd23) begin
            errors++; $display("FAIL invalid_then_valid: actual erro=%b indice=%0d required erro=0 indice=23", e, idx);
        end
        checks++;
    endtask

    task automatic test_random();
        int lat, bl;
        logic [4:0] idx, r;
        logic e, dp;
        logic [7:0] p;
        for (int n = 0; n < 40; n++) begin
            p = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 23)] : 8'($urandom);
            ref_model(p, r, dp);
            do_job(p, lat, idx, e, bl);
            if (idx !== r || e !== dp || lat !== (dp ? 1 : 4) || bl != 0) begin
                errors++;
                $display("FAIL random %h: actual indice=%0d erro=%b lat=%0d busy_low=%0d required indice=%0d erro=%b lat=%0d busy_low=0",
                         p, idx, e, lat, bl, r, dp, dp ? 1 : 4);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        int ndone;
        logic [4:0] last;
        @(posedge clock); #1;
        perm = 8'h4B; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        ndone = 0; last = '0;
        for (int k = 0; k < 16; k++) begin
            if (done) begin ndone++; last = indice; end
            start = (k == 2);
            perm = 8'hE4;
            @(posedge clock); #1;
        end
        start = 1'b0;
        if (ndone !== 1) begin errors++; $display("FAIL start_while_busy_dones: actual %0d required 1", ndone); end
        checks++;
        if (last !== 5'd6) begin errors++; $display("FAIL start_while_busy_indice: actual %0d required 6", last); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int lat, bl, ndone;
        logic [4:0] idx;
        logic e;
        do_job(8'hE4, lat, idx, e, bl);
        @(posedge clock); #1;
        perm = 8'h1B; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        if (busy !== 1'b0 || done !== 1'b0 || indice !== 5'd0 || erro !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: actual busy=%b done=%b indice=%0d erro=%b required 0 0 0 0",
                     busy, done, indice, erro);
        end
        checks++;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) ndone++;
            @(posedge clock); #1;
        end
        if (ndone != 0) begin errors++; $display("FAIL reset_mid_no_done: actual %0d active cycles required 0", ndone); end
        checks++;
    endtask

`ifdef RANK_ERR_CNT_EN
    task automatic test_err_cnt();
        int lat, bl;
        logic [4:0] idx;
        logic e;
        do_reset();
        for (int n = 0; n < 3; n++) do_job(8'h00, lat, idx, e, bl);
        do_job(8'h1B, lat, idx, e, bl);
        if (erros_cnt !== 8'd3) begin errors++; $display("FAIL err_cnt_3: actual %0d required 3", erros_cnt); end
        checks++;
        for (int n = 0; n < 257; n++) do_job(8'h06, lat, idx, e, bl);
        if (erros_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_sat: actual %0d required 255", erros_cnt); end
        checks++;
        do_reset();
        if (erros_cnt !== 8'd0) begin errors++; $display("FAIL err_cnt_reset: actual %0d required 0", erros_cnt); end
        checks++;
    endtask
`endif

    initial begin
        reset = 1'b0; start = 1'b0; perm = 8'h00;
        build_table();
        test_reset();
        test_known();
        test_round_trip();
        test_invalid();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef RANK_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
